// File: rtl/cla_digit_serial_adder.sv
// ---------------------------------------------------------------------------
// cla_digit_serial_adder
//   Multi-cycle WIDTH-bit adder. One 4-bit carry-lookahead slice is reused
//   once per clock, least significant nibble first. A carry register links
//   each nibble to the next. The sum is shifted in from the top, so after
//   N = WIDTH/4 RUN edges it sits fully aligned in sum.
//   It also reports two's-complement overflow of the full-width add.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operands valid          in_ready   block can accept operands
//   a, b       WIDTH-bit addends       c_in       carry in
//   out_valid  result valid            out_ready  consumer accepts result
//   sum        registered sum          c_out      registered carry out
//   ovf        registered signed overflow
//
// WIDTH must be a multiple of 4 and at least 4.
// ---------------------------------------------------------------------------

module four_bit_carry_lookahead_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is flattened into generate/propagate terms, so no carry
  // ripples through the slice.
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum   = p ^ c[3:0];
  assign c_out = c[4];
endmodule

module cla_digit_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             msb_a_q, msb_a_d;
  logic             msb_b_q, msb_b_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] sum_shift;

  four_bit_carry_lookahead_adder u_slice (
    .a    (a_sh_q[3:0]),
    .b    (b_sh_q[3:0]),
    .c_in (carry_q),
    .sum  (slice_sum),
    .c_out(slice_cout)
  );

  // Each new nibble enters at the top. After N shifts the first nibble
  // has reached bit 0. With one nibble there is nothing to shift down.
  generate
    if (WIDTH == 4) begin : g_sum_narrow
      assign sum_shift = slice_sum;
    end else begin : g_sum_wide
      assign sum_shift = {slice_sum, sum_q[WIDTH-1:4]};
    end
  endgenerate

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_d       = sum_q;
    count_d     = count_q;
    carry_d     = carry_q;
    msb_a_d     = msb_a_q;
    msb_b_d     = msb_b_q;
    c_out_d     = c_out_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = c_in;
          count_d = '0;
          msb_a_d = a[WIDTH-1];
          msb_b_d = b[WIDTH-1];
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = sum_shift;
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        carry_d = slice_cout;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          c_out_d     = slice_cout;
          // The carry into the MSB is a^b^s at that bit. XOR it with the
          // carry out to get two's-complement overflow.
          ovf_d       = slice_cout ^ msb_a_q ^ msb_b_q ^ slice_sum[3];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      count_q     <= '0;
      carry_q     <= 1'b0;
      msb_a_q     <= 1'b0;
      msb_b_q     <= 1'b0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      carry_q     <= carry_d;
      msb_a_q     <= msb_a_d;
      msb_b_q     <= msb_b_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_cla_digit_serial_adder.sv
module tb_cla_digit_serial_adder;
  localparam int W = 16;
  localparam int N = W / 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  a, b, sum;
  logic          c_in, c_out, ovf;

  logic          in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0]    a4, b4, sum4;
  logic          c_in4, c_out4, ovf4;

  cla_digit_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  cla_digit_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .c_in(c_in4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .c_out(c_out4), .ovf(ovf4)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  function automatic exp_t model16(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci);
    exp_t e;
    logic [W:0] r;
    r   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.s = r[W-1:0];
    e.c = r[W];
    e.v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    return e;
  endfunction

  // Called at the negedge after the accepting edge. It counts the edges
  // until out_valid appears, with a bounded wait.
  task automatic wait16(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run16(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input string name);
    int   lat;
    exp_t e;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s in_ready actual=%b required=1", name, in_ready);
    end
    in_valid = 1'b1; a = x; b = y; c_in = ci;
    q.push_back(model16(x, y, ci));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait16(lat);
    total++;
    if (lat !== N) begin
      bad++;
      $display("FAIL %s latency actual=%0d required=%0d", name, lat, N);
    end
    if (q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s scoreboard empty actual=0 required=1", name);
      return;
    end
    e = q.pop_front();
    total++;
    if (sum !== e.s || c_out !== e.c || ovf !== e.v) begin
      bad++;
      $display("FAIL %s result actual=%h/%b/%b required=%h/%b/%b",
               name, sum, c_out, ovf, e.s, e.c, e.v);
    end
    $display("op %s a=%h b=%h cin=%b -> sum=%h c=%b ovf=%b lat=%0d",
             name, x, y, ci, sum, c_out, ovf, lat);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s post_handshake actual=%b/%b required=0/1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; c_in4 = 1'b0; out_ready4 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || sum !== '0 || c_out !== 1'b0 || ovf !== 1'b0
        || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_state actual=%b/%h/%b/%b/%b required=0/0000/0/0/0",
               out_valid, sum, c_out, ovf, in_ready);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || in_ready4 !== 1'b1) begin
      bad++;
      $display("FAIL reset_release in_ready actual=%b/%b required=1/1",
               in_ready, in_ready4);
    end
    $display("reset done in_ready=%b", in_ready);
    @(negedge clk);
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    run16(16'h1234, 16'h4321, 1'b0, "basic_1234");
    run16(16'hFFFF, 16'h0000, 1'b1, "carry_chain");
    run16(16'h7FFF, 16'h0001, 1'b0, "pos_overflow");
    run16(16'h8000, 16'h8000, 1'b0, "neg_overflow");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run16(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e;
    logic [W-1:0] x2, y2;
    x2 = 16'hABCD;
    y2 = 16'h1357;
    out_ready = 1'b0;
    in_valid = 1'b1; a = 16'h0F0F; b = 16'h0101; c_in = 1'b1;
    q.push_back(model16(16'h0F0F, 16'h0101, 1'b1));
    @(posedge clk);
    @(negedge clk);
    // New operands stay offered through RUN and DONE and must be ignored.
    a = x2; b = y2; c_in = 1'b0;
    q.push_back(model16(x2, y2, 1'b0));
    wait16(lat);
    total++;
    if (lat !== N) begin
      bad++;
      $display("FAIL bp_latency actual=%0d required=%0d", lat, N);
    end
    e = q.pop_front();
    total++;
    if (sum !== e.s || c_out !== e.c || ovf !== e.v) begin
      bad++;
      $display("FAIL bp_result actual=%h/%b/%b required=%h/%b/%b",
               sum, c_out, ovf, e.s, e.c, e.v);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== e.s
          || c_out !== e.c || ovf !== e.v) begin
        bad++;
        $display("FAIL bp_hold%0d actual=%b/%b/%h/%b/%b required=1/0/%h/%b/%b",
                 i, out_valid, in_ready, sum, c_out, ovf, e.s, e.c, e.v);
      end
    end
    $display("op backpressure held sum=%h c=%b ovf=%b", sum, c_out, ovf);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release actual=%b/%b required=0/1", out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait16(lat);
    total++;
    if (lat !== N) begin
      bad++;
      $display("FAIL bp_second_latency actual=%0d required=%0d", lat, N);
    end
    e = q.pop_front();
    total++;
    if (sum !== e.s || c_out !== e.c || ovf !== e.v) begin
      bad++;
      $display("FAIL bp_second_result actual=%h/%b/%b required=%h/%b/%b",
               sum, c_out, ovf, e.s, e.c, e.v);
    end
    $display("op backpressure second a=%h b=%h -> sum=%h c=%b ovf=%b",
             x2, y2, sum, c_out, ovf);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic seen;
    out_ready = 1'b1;
    in_valid = 1'b1; a = 16'hFFFF; b = 16'h1111; c_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid in_ready_during actual=%b required=0", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || sum !== '0 || c_out !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid outputs actual=%b/%h/%b/%b required=0/0000/0/0",
               out_valid, sum, c_out, ovf);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid in_ready_after actual=%b required=1", in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid stray_out_valid actual=1 required=0");
    end
    $display("op reset_mid aborted, no result presented");
  endtask

  task automatic test_w4();
    logic [3:0] ta [5] = '{4'h9, 4'hF, 4'h7, 4'h0, 4'h5};
    logic [3:0] tb [5] = '{4'h8, 4'h1, 4'h1, 4'h0, 4'hA};
    logic       tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [4:0] r;
    logic       v;
    int         lat;
    out_ready4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      r = {1'b0, ta[i]} + {1'b0, tb[i]} + {4'b0, tc[i]};
      v = (ta[i][3] == tb[i][3]) && (r[3] != ta[i][3]);
      in_valid4 = 1'b1; a4 = ta[i]; b4 = tb[i]; c_in4 = tc[i];
      @(posedge clk);
      @(negedge clk);
      in_valid4 = 1'b0;
      lat = 0;
      while (!out_valid4 && lat < 10) begin
        @(posedge clk);
        @(negedge clk);
        lat++;
      end
      total++;
      if (lat !== 1 || sum4 !== r[3:0] || c_out4 !== r[4] || ovf4 !== v) begin
        bad++;
        $display("FAIL w4_op%0d actual=lat%0d/%h/%b/%b required=lat1/%h/%b/%b",
                 i, lat, sum4, c_out4, ovf4, r[3:0], r[4], v);
      end
      $display("op w4 a=%h b=%h cin=%b -> sum=%h c=%b ovf=%b lat=%0d",
               ta[i], tb[i], tc[i], sum4, c_out4, ovf4, lat);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_w4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/cla_digit_serial_adder.md
Name: cla_digit_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder that time-shares one four_bit_carry_lookahead_adder slice, one nibble per clock, LSB nibble first.
- A registered carry links successive nibbles.
- Valid/ready handshake on input and output, so it can sit between producer and consumer stages where area matters more than latency.
- Also reports signed overflow.

Parameters:
- WIDTH, 16, operand/sum width in bits. Must be a multiple of 4 and >= 4. N = WIDTH/4 is the nibble count.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  addend
- b  input  WIDTH  addend
- c_in  input  1  carry in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered sum
- c_out  output  1  registered carry out
- ovf  output  1  registered signed overflow

Behaviour:
- Sole clock is clk. Reset is synchronous and active-high: rst sampled high at a rising edge of clk.
- Reset state: state=IDLE, out_valid=0, sum=0, c_out=0, ovf=0, internal carry/count/operand registers=0.
- in_ready = (state==IDLE) && !rst, combinational.
- Single slice instance. Its inputs are the low nibbles of the operand shift registers plus the carry register.
- States:
  - IDLE: on edge with in_valid && in_ready:
    - load a_sh=a, b_sh=b, carry=c_in, count=0
    - latch a[WIDTH-1], b[WIDTH-1] as msb_a/msb_b
    - go to RUN.
    - Otherwise stay in IDLE.
  - RUN: each edge:
    - shift slice sum nibble into sum register from the top: sum <= {slice_sum, sum[WIDTH-1:4]}
    - a_sh/b_sh shift right 4
    - carry <= slice carry out
    - count++.
    - When count==N-1 on that edge:
      - c_out <= slice carry out
      - ovf <= slice carry out ^ msb_a ^ msb_b ^ slice_sum[3]
      - out_valid <= 1
      - go to DONE.
  - DONE: sum, c_out, ovf and out_valid held stable. On edge with out_valid && out_ready: out_valid <= 0, go to IDLE. sum/c_out/ovf keep last values until next completion.
- Latency: out_valid rises exactly N edges after the accepting edge. Throughput: one operation per N+2 cycles minimum; in_ready is low from the accepting edge until the edge after the output handshake.
- No new operands are accepted in RUN or DONE. in_valid is ignored there and must not disturb the in-flight operation.
- out_valid never drops without out_ready (AXI-style). sum/c_out/ovf must not change while out_valid=1.
- Arithmetic: {c_out,sum} = a + b + c_in, modulo 2^(WIDTH+1). ovf = carry into MSB XOR carry out of MSB (two's-complement overflow).
- Reset mid-operation (RUN or DONE): return to IDLE on that edge, all outputs zeroed, no result presented afterward for the aborted operation.
- rst has priority over every handshake in the same cycle.
- WIDTH=4 (N=1): RUN lasts exactly one edge.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, c_in=0 -> out_valid 4 edges after accept; sum=0x5555, c_out=0, ovf=0.
- WIDTH=16, a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000, c_out=1, ovf=0 (carry crosses every nibble boundary via carry register).
- WIDTH=16, a=0x7FFF, b=0x0001, c_in=0 -> sum=0x8000, c_out=0, ovf=1.
- Back-pressure: hold out_ready=0 for 3 cycles after out_valid while driving in_valid=1 with new operands -> out_valid/sum/c_out/ovf stable, in_ready=0. After out_ready=1 handshake, in_ready=1 next cycle and the new operands are accepted and correctly summed.
- Assert rst for one cycle during RUN (count=2) -> next cycle state IDLE, out_valid=0, sum=0, c_out=0, in_ready=1 after rst drops. No out_valid pulse appears later.
- WIDTH=4 instance, a=0x9, b=0x8, c_in=0 -> out_valid 1 edge after accept; sum=0x1, c_out=1, ovf=1.
